// File: rtl/io_step_sched_if.sv
// io_step_sched_if: control flags, IO pins and timer enable of the step scheduler
interface io_step_sched_if #(parameter int IN_W = 14);
  logic            cpu_edge;
  logic            inop;
  logic            outop;
  logic            sleep;
  logic            bt;
  logic [IN_W-1:0] in;
  logic [31:0]     dm;
  logic [31:0]     du;
  logic [31:0]     disp_val;
  logic            update;
  logic            await;
  logic [1:0]      st;
  modport master (output cpu_edge, inop, outop, sleep, bt, in, dm,
                  input du, disp_val, update, await, st);
  modport slave (input cpu_edge, inop, outop, sleep, bt, in, dm,
                 output du, disp_val, update, await, st);
endinterface

// File: rtl/io_step_sched.sv
// io_step_sched: gates the CPU step clock around IN (button wait), OUT (display latch) and SLEEP (fixed stall)
module io_step_sched #(
  parameter int DEBOUNCE     = 16,
  parameter int SLEEP_CYCLES = 1000,
  parameter int IN_W         = 14
) (
  input logic            clk,
  input logic            bt_reset,
  io_step_sched_if.slave io
);
  localparam int DCW = $clog2(DEBOUNCE);
  localparam int SCW = $clog2(SLEEP_CYCLES + 1);
  typedef enum logic [1:0] {RUN = 2'd0, WAIT_IN = 2'd1, SLP = 2'd2, BAD = 2'd3} state_t;
  state_t         st_q, st_d;
  logic           sync1_q, sync1_d, sync2_q, sync2_d;
  logic           db_q, db_d, armed_q, armed_d;
  logic [DCW-1:0] dcnt_q, dcnt_d;
  logic [SCW-1:0] scnt_q, scnt_d;
  logic           upd_q, upd_d, await_q, await_d;
  logic [31:0]    du_q, du_d, disp_q, disp_d;
  logic           diff, tog, press;
  // button debounce/arming and scheduler next state
  always_comb begin
    sync1_d = io.bt;
    sync2_d = sync1_q;
    diff    = sync2_q != db_q;
    tog     = diff && dcnt_q == DCW'(DEBOUNCE - 1);
    db_d    = db_q ^ tog;
    dcnt_d  = (diff && !tog) ? dcnt_q + 1'b1 : '0;
    press   = tog && !db_q && armed_q;
    armed_d = (tog && db_q) ? 1'b1 : press ? 1'b0 : armed_q;
    st_d    = st_q;
    upd_d   = upd_q;
    await_d = await_q;
    du_d    = du_q;
    disp_d  = disp_q;
    scnt_d  = scnt_q;
    case (st_q)
      RUN: if (io.cpu_edge) begin
        if (io.outop) disp_d = io.dm;
        if (io.inop) begin
          st_d    = WAIT_IN;
          upd_d   = 1'b0;
          await_d = 1'b1;
        end else if (io.sleep) begin
          st_d   = SLP;
          scnt_d = SCW'(SLEEP_CYCLES - 1);
          upd_d  = 1'b0;
        end
      end
      WAIT_IN: if (press) begin
        du_d    = 32'(io.in);
        st_d    = RUN;
        upd_d   = 1'b1;
        await_d = 1'b0;
      end
      SLP: begin
        st_d   = scnt_q == '0 ? RUN : SLP;
        upd_d  = scnt_q == '0;
        scnt_d = scnt_q == '0 ? scnt_q : scnt_q - 1'b1;
      end
      default: begin
        st_d    = RUN;
        upd_d   = 1'b1;
        await_d = 1'b0;
      end
    endcase
  end
  // state registers, asynchronously reset to the run state
  always_ff @(posedge clk or negedge bt_reset) begin
    if (!bt_reset) begin
      st_q    <= RUN;
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      db_q    <= 1'b0;
      armed_q <= 1'b1;
      dcnt_q  <= '0;
      scnt_q  <= '0;
      upd_q   <= 1'b1;
      await_q <= 1'b0;
      du_q    <= '0;
      disp_q  <= '0;
    end else begin
      st_q    <= st_d;
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      db_q    <= db_d;
      armed_q <= armed_d;
      dcnt_q  <= dcnt_d;
      scnt_q  <= scnt_d;
      upd_q   <= upd_d;
      await_q <= await_d;
      du_q    <= du_d;
      disp_q  <= disp_d;
    end
  end
  assign io.st       = st_q;
  assign io.update   = upd_q;
  assign io.await    = await_q;
  assign io.du       = du_q;
  assign io.disp_val = disp_q;
endmodule

// File: tb/tb_io_step_sched.sv
// tb_io_step_sched: randomized and directed checks of io_step_sched against a behavioural model
module tb_io_step_sched;
  localparam int D  = 4;
  localparam int SC = 5;
  localparam int IW = 14;
  logic clk = 1'b0;
  logic bt_reset = 1'b0;
  int total = 0;
  int bad = 0;
  io_step_sched_if #(.IN_W(IW)) io();
  io_step_sched #(.DEBOUNCE(D), .SLEEP_CYCLES(SC), .IN_W(IW)) dut (.clk(clk), .bt_reset(bt_reset), .io(io.slave));
  always #5 clk = ~clk;
  // model: mode 0=run 1=wait 2=sleep
  logic hist[$];
  logic m_db, m_armed;
  int m_mode, m_left;
  logic [31:0] m_du, m_disp;
  task automatic model_reset();
    hist = '{1'b0, 1'b0};
    m_db = 0; m_armed = 1; m_mode = 0; m_left = 0; m_du = 0; m_disp = 0;
  endtask
  task automatic model_edge();
    logic tog, press;
    hist.push_back(io.bt);
    tog = 1;
    for (int i = 0; i < D; i++) begin
      int k = hist.size() - 3 - i;
      if (k < 0 || hist[k] == m_db) tog = 0;
    end
    while (hist.size() > D + 3) hist.delete(0);
    press = tog && !m_db && m_armed;
    if (tog && m_db) m_armed = 1; else if (press) m_armed = 0;
    if (tog) m_db = !m_db;
    if (m_mode == 0 && io.cpu_edge) begin
      if (io.outop) m_disp = io.dm;
      if (io.inop) m_mode = 1;
      else if (io.sleep) begin m_mode = 2; m_left = SC; end
    end else if (m_mode == 1 && press) begin
      m_du = 32'(io.in);
      m_mode = 0;
    end else if (m_mode == 2) begin
      m_left--;
      if (m_left == 0) m_mode = 0;
    end
  endtask
  task automatic tick();
    @(posedge clk);
    if (!bt_reset) model_reset(); else model_edge();
    #1;
  endtask
  task automatic pulse(input logic i, input logic o, input logic s, input logic [31:0] d, input logic [IW-1:0] v);
    io.cpu_edge = 1; io.inop = i; io.outop = o; io.sleep = s; io.dm = d; io.in = v;
    tick();
    io.cpu_edge = 0; io.inop = 0; io.outop = 0; io.sleep = 0;
  endtask
  task automatic test_reset();
    io.cpu_edge = 0; io.inop = 0; io.outop = 0; io.sleep = 0; io.bt = 0; io.in = 0; io.dm = 0;
    bt_reset = 0;
    model_reset();
    repeat (3) tick();
    bt_reset = 1;
    for (int c = 0; c < 20; c++) begin
      tick();
      total++;
      if (io.st !== 2'd0 || io.update !== 1'b1 || io.await !== 1'b0 || io.du !== 32'd0 || io.disp_val !== 32'd0) begin
        bad++;
        $display("FAIL reset_idle cyc=%0d got st=%0d upd=%b aw=%b du=%h disp=%h want 0 1 0 0 0", c, io.st, io.update, io.await, io.du, io.disp_val);
      end
    end
  endtask
  task automatic test_out();
    pulse(0, 1, 0, 32'h0000_00A5, 0);
    total++;
    if (io.disp_val !== 32'hA5 || io.update !== 1'b1 || io.st !== 2'd0) begin
      bad++;
      $display("FAIL out_latch got disp=%h upd=%b st=%0d want a5 1 0", io.disp_val, io.update, io.st);
    end
  endtask
  task automatic test_in_bounce();
    int n;
    pulse(1, 0, 0, 0, 14'h1234);
    for (int c = 0; c < 30; c++) begin
      io.bt = ((c / 3) % 2) == 0;
      tick();
      total++;
      if (io.await !== 1'b1 || io.update !== 1'b0 || io.st !== 2'd1) begin
        bad++;
        $display("FAIL in_bounce cyc=%0d got aw=%b upd=%b st=%0d want 1 0 1", c, io.await, io.update, io.st);
      end
    end
    io.bt = 1;
    n = 0;
    while (io.update !== 1'b1 && n < 50) begin tick(); n++; end
    total++;
    if (n !== D + 2) begin bad++; $display("FAIL in_latency got %0d want %0d", n, D + 2); end
    total++;
    if (io.du !== 32'h0000_1234 || io.await !== 1'b0 || m_du !== 32'h1234) begin
      bad++;
      $display("FAIL in_capture got du=%h aw=%b want 00001234 0", io.du, io.await);
    end
  endtask
  task automatic test_held();
    int n;
    pulse(1, 0, 0, 0, 14'h2AAA);
    for (int c = 0; c < 20; c++) begin
      tick();
      total++;
      if (io.await !== 1'b1 || io.update !== 1'b0) begin
        bad++;
        $display("FAIL held_wait cyc=%0d got aw=%b upd=%b want 1 0", c, io.await, io.update);
      end
    end
    io.bt = 0;
    repeat (D + 4) tick();
    total++;
    if (io.await !== 1'b1) begin bad++; $display("FAIL release_wait got aw=%b want 1", io.await); end
    io.bt = 1;
    n = 0;
    while (io.update !== 1'b1 && n < 50) begin tick(); n++; end
    total++;
    if (n !== D + 2 || io.du !== 32'h0000_2AAA) begin
      bad++;
      $display("FAIL held_resume got n=%0d du=%h want %0d 00002aaa", n, io.du, D + 2);
    end
    io.bt = 0;
    repeat (D + 4) tick();
  endtask
  task automatic test_sleep();
    logic [1:0] exp_st[6] = '{2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd0};
    total++;
    if (io.st !== 2'd0) begin bad++; $display("FAIL sleep_pre got st=%0d want 0", io.st); end
    pulse(0, 0, 1, 0, 0);
    for (int c = 0; c < 6; c++) begin
      total++;
      if (io.st !== exp_st[c] || io.update !== (c == 5)) begin
        bad++;
        $display("FAIL sleep_seq cyc=%0d got st=%0d upd=%b want %0d %b", c, io.st, io.update, exp_st[c], c == 5);
      end
      if (c < 5) tick();
    end
  endtask
  task automatic test_combo_reset();
    pulse(1, 1, 1, 32'd7, 0);
    tick();
    total++;
    if (io.st !== 2'd1 || io.disp_val !== 32'd7 || io.update !== 1'b0) begin
      bad++;
      $display("FAIL combo got st=%0d disp=%h upd=%b want 1 7 0", io.st, io.disp_val, io.update);
    end
    #2 bt_reset = 0;
    #1;
    model_reset();
    total++;
    if (io.st !== 2'd0 || io.update !== 1'b1 || io.du !== 32'd0 || io.disp_val !== 32'd0 || io.await !== 1'b0) begin
      bad++;
      $display("FAIL async_reset got st=%0d upd=%b du=%h disp=%h aw=%b want 0 1 0 0 0", io.st, io.update, io.du, io.disp_val, io.await);
    end
    tick();
    bt_reset = 1;
  endtask
  task automatic test_random();
    int hold = 0;
    logic prev_edge = 0;
    for (int c = 0; c < 3000; c++) begin
      if (hold == 0) begin io.bt = $urandom_range(0, 1); hold = $urandom_range(1, 9); end
      hold--;
      io.cpu_edge = !prev_edge && ($urandom_range(0, 3) == 0);
      io.inop = $urandom_range(0, 2) == 0;
      io.outop = $urandom_range(0, 1);
      io.sleep = $urandom_range(0, 1);
      io.in = IW'($urandom);
      io.dm = $urandom;
      prev_edge = io.cpu_edge;
      tick();
      total++;
      if (io.st !== 2'(m_mode) || io.update !== (m_mode == 0) || io.await !== (m_mode == 1) || io.du !== m_du || io.disp_val !== m_disp) begin
        bad++;
        $display("FAIL random cyc=%0d got st=%0d upd=%b aw=%b du=%h disp=%h want %0d %b %b %h %h", c, io.st, io.update, io.await, io.du, io.disp_val, m_mode, m_mode == 0, m_mode == 1, m_du, m_disp);
      end
    end
  endtask
  initial begin
    test_reset();
    test_out();
    test_in_bounce();
    test_held();
    test_sleep();
    test_combo_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/io_step_sched.md
Name: io_step_sched

Overview:
- Scheduler for the CPU step clock. Owns the `update` enable of the timer and sequences IN, OUT and SLEEP instructions.
- Stalls the CPU on an IN until a debounced user button press, then captures the switch value into `du`.
- On OUT, latches `dm` into a display register.
- On SLEEP, stalls the CPU for a fixed number of cycles.
- Sits between the control unit flags, the IO pins and the timer, all on the divided clock.

Parameters:
- DEBOUNCE, 16: cycles the raw button must stay stable before its debounced level changes (≥2).
- SLEEP_CYCLES, 1000: stall length in clk cycles for SLEEP (≥1).
- IN_W, 14: switch input width (≤32).

Ports:
- clk  in  1  divided system clock; all logic is on its rising edge.
- bt_reset  in  1  asynchronous, active-low reset.
- cpu_edge  in  1  one-clk pulse marking a CPU clock rising edge (instruction boundary).
- inop  in  1  IN instruction flag from the control unit; sampled only when cpu_edge=1.
- outop  in  1  OUT instruction flag; sampled only when cpu_edge=1.
- sleep  in  1  SLEEP instruction flag; sampled only when cpu_edge=1.
- bt  in  1  raw user button, active-high, asynchronous to clk.
- in  in  IN_W  switch value.
- dm  in  32  data memory output, the OUT source.
- du  out  32  captured user input, zero-extended in[IN_W-1:0].
- disp_val  out  32  value latched by the last OUT.
- update  out  1  timer enable; 1 = CPU may step.
- await  out  1  1 while waiting for user input.
- st  out  2  state code: RUN=0, WAIT_IN=1, SLEEP=2.

Behaviour:
- **Reset** (bt_reset=0, async), all registered:
  - st=RUN, update=1, await=0, du=0, disp_val=0
  - sleep counter=0, debounce counter=0
  - debounced level db=0, armed=1
- **Input sync/debounce**
  - bt passes through a 2-flop synchronizer.
  - If synced≠db, the debounce counter increments; otherwise it clears.
  - When the counter reaches DEBOUNCE-1, db toggles and the counter clears.
  - press = rising edge of db while armed=1. A press clears armed.
  - db falling sets armed=1. Each IN therefore needs a fresh press-release cycle; a held button never satisfies two INs.
- **RUN**, on cpu_edge:
  - outop=1: disp_val<=dm next cycle. This happens in any combination with the other flags.
  - inop=1: st<=WAIT_IN, update<=0, await<=1.
  - else sleep=1: st<=SLEEP, load counter with SLEEP_CYCLES-1, update<=0.
  - inop has priority over sleep.
  - cpu_edge=0: no state change.
- **WAIT_IN**
  - update=0, await=1; the state persists indefinitely.
  - On the press cycle: du<={zeros, in}, st<=RUN, update<=1, await<=0. All registered, visible the following cycle.
  - A press that occurred before entering WAIT_IN (armed already cleared) does not count.
- **SLEEP**
  - update=0; the counter decrements each cycle.
  - When the counter is 0: st<=RUN, update<=1.
  - update is low for exactly SLEEP_CYCLES cycles after the cpu_edge cycle.
  - Presses in SLEEP or RUN are consumed by debounce/arming only and never modify du.
- **Timing**
  - update drops one clk after the triggering cpu_edge.
  - The timer period must be ≥2 clk cycles so no further edge is issued before update falls.
- cpu_edge in WAIT_IN or SLEEP: ignored.
- Reset mid-WAIT_IN or mid-SLEEP: immediate return to RUN with the reset values above.
- Unused state code 3 → RUN next cycle, update=1.

Test Plan:
1. Reset then idle → st=0, update=1, await=0, du=0, disp_val=0 for 20 cycles.
2. cpu_edge with outop=1, dm=0x0000_00A5 → disp_val=0xA5 next cycle; update stays 1.
3. cpu_edge with inop=1, in=0x1234; bt bounces 0/1 every 3 cycles for 30 cycles, then held high → await=1 and update=0 until DEBOUNCE+2 cycles of stable high. Then du=0x0000_1234, await=0, update=1.
4. Button held high through a second IN → await stays 1. Release for DEBOUNCE cycles, then press → resumes with the new in value.
5. SLEEP_CYCLES=5, cpu_edge with sleep=1 → update=0 for exactly 5 cycles, then 1; st sequence 0,2,2,2,2,2,0.
6. Flags inop=1, sleep=1, outop=1 together, dm=7 → st=WAIT_IN and disp_val=7. Assert bt_reset=0 mid-wait → async st=0, update=1, du=0, disp_val=0.
